bcd_to_binary: RTL and testbench



---
 rtl/bcd_to_binary.sv | 142 ++++++++++++++
 tb/tb_bcd_to_binary.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential three-digit BCD to 10-bit binary converter.
// A reverse double-dabble loop runs for ten cycles: each cycle shifts the
// low BCD bit into the top of the accumulator, then subtracts 3 from any
// BCD digit field that has reached 8 or more. Illegal digits skip the loop
// and report ERR. All outputs are registered.
module bcd_to_binary (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] HUNDREDS,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  output logic [9:0] BIN,
  output logic       busy,
  output logic       done,
  output logic       ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [9:0] bcd_r, bcd_s;
  logic [9:0] acc_r, acc_s;
  logic [3:0] cnt_r, cnt_s;
  logic [9:0] bin_r, bin_s;
  logic       err_r, err_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;

  logic [9:0] shift_s;
  logic [9:0] step_bcd_s;
  logic [9:0] step_acc_s;

  // Undo the doubling of one BCD digit: a field of 8 or more held a carry
  // from the digit above, which is worth 5 here after halving, not 8.
  function automatic logic [3:0] fix_digit(input logic [3:0] d);
    if (d >= 4'd8) begin
      return d - 4'd3;
    end else begin
      return d;
    end
  endfunction

  // Next-state and next-register values for the whole converter.
  always_comb begin
    state_s    = state_r;
    bcd_s      = bcd_r;
    acc_s      = acc_r;
    cnt_s      = cnt_r;
    bin_s      = bin_r;
    err_s      = err_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    shift_s    = {1'b0, bcd_r[9:1]};
    step_bcd_s = {shift_s[9:8], fix_digit(shift_s[7:4]), fix_digit(shift_s[3:0])};
    step_acc_s = {bcd_r[0], acc_r[9:1]};

    case (state_r)
      IDLE: begin
        if (start) begin
          busy_s = 1'b1;
          if ((TENS > 4'd9) || (ONES > 4'd9)) begin
            bin_s   = 10'd0;
            err_s   = 1'b1;
            state_s = DONE;
          end else begin
            bcd_s   = {HUNDREDS, TENS, ONES};
            acc_s   = 10'd0;
            cnt_s   = 4'd0;
            err_s   = 1'b0;
            state_s = CONVERT;
          end
        end else begin
          state_s = IDLE;
        end
      end

      CONVERT: begin
        bcd_s = step_bcd_s;
        acc_s = step_acc_s;
        if (cnt_r == 4'd9) begin
          bin_s   = step_acc_s;
          cnt_s   = 4'd0;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end

      DONE: begin
        // A conversion enters with done already set and leaves next edge;
        // an illegal request enters with done clear, so it spends one
        // extra cycle here to raise done for exactly one cycle.
        if (done_r) begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          done_s = 1'b1;
        end
      end

      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      bcd_r   <= 10'd0;
      acc_r   <= 10'd0;
      cnt_r   <= 4'd0;
      bin_r   <= 10'd0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      bcd_r   <= bcd_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      bin_r   <= bin_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign BIN  = bin_r;
  assign ERR  = err_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary. Expected {ERR,BIN} results are
// queued when a request is driven and popped when done is observed.
module tb_bcd_to_binary;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] HUNDREDS;
  logic [3:0] TENS;
  logic [3:0] ONES;
  logic [9:0] BIN;
  logic       busy;
  logic       done;
  logic       ERR;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] sb[$];

  bcd_to_binary dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .HUNDREDS (HUNDREDS),
    .TENS     (TENS),
    .ONES     (ONES),
    .BIN      (BIN),
    .busy     (busy),
    .done     (done),
    .ERR      (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference binary-to-BCD stage (shift / add-3) for the round trip.
  function automatic logic [11:0] bin2bcd(input logic [9:0] b);
    logic [21:0] s;
    s = {12'd0, b};
    for (int i = 0; i < 10; i++) begin
      if (s[13:10] >= 4'd5) s[13:10] = s[13:10] + 4'd3;
      if (s[17:14] >= 4'd5) s[17:14] = s[17:14] + 4'd3;
      if (s[21:18] >= 4'd5) s[21:18] = s[21:18] + 4'd3;
      s = s << 1;
    end
    return s[21:10];
  endfunction

  // Drive one request from a negedge, queue its expectation and wait for
  // done. edges = clock edges from acceptance to done, or -1 on timeout.
  task automatic do_req(input logic [1:0] h, input logic [3:0] t,
                        input logic [3:0] o, input bit scramble,
                        output int edges);
    HUNDREDS = h;
    TENS     = t;
    ONES     = o;
    start    = 1'b1;
    if ((t > 4'd9) || (o > 4'd9))
      sb.push_back({1'b1, 10'd0});
    else
      sb.push_back({1'b0, 10'(100 * int'(h) + 10 * int'(t) + int'(o))});
    edges = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
        HUNDREDS = 2'($urandom_range(3, 0));
        TENS     = 4'($urandom_range(15, 0));
        ONES     = 4'($urandom_range(15, 0));
      end
      if (done) begin
        edges = c - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; HUNDREDS = 2'd0; TENS = 4'd0; ONES = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({BIN, ERR, busy, done} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got BIN=%h ERR=%b busy=%b done=%b, want all 0", BIN, ERR, busy, done);
    end
  endtask

  task automatic test_max();
    int e;
    logic [10:0] exp_v;
    do_req(2'd3, 4'd9, 4'd9, 1'b0, e);
    exp_v = sb.pop_front();
    n_checks++;
    if (e !== 10) begin n_fail++; $display("FAIL max_latency: got %0d edges, want 10", e); end
    n_checks++;
    if (BIN !== 10'h18F || BIN !== exp_v[9:0]) begin n_fail++; $display("FAIL max_bin: got %h, want 18f", BIN); end
    n_checks++;
    if (ERR !== exp_v[10]) begin n_fail++; $display("FAIL max_err: got %b, want %b", ERR, exp_v[10]); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL max_busy_at_done: got %b, want 1", busy); end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL max_after_done: got busy=%b done=%b, want 0 0", busy, done); end
  endtask

  task automatic test_sweep();
    int e;
    logic [10:0] exp_v;
    logic [11:0] rt;
    for (int h = 0; h < 4; h++) begin
      for (int t = 0; t < 10; t++) begin
        for (int o = 0; o < 10; o++) begin
          do_req(2'(h), 4'(t), 4'(o), 1'b0, e);
          exp_v = sb.pop_front();
          n_checks++;
          if (e !== 10 || BIN !== exp_v[9:0] || ERR !== exp_v[10]) begin
            n_fail++;
            $display("FAIL sweep_%0d%0d%0d: got BIN=%0d ERR=%b edges=%0d, want BIN=%0d ERR=%b edges=10",
                     h, t, o, BIN, ERR, e, exp_v[9:0], exp_v[10]);
          end
          rt = bin2bcd(BIN);
          n_checks++;
          if (rt !== {4'(h), 4'(t), 4'(o)}) begin
            n_fail++;
            $display("FAIL roundtrip_%0d%0d%0d: got digits %h, want %0d%0d%0d", h, t, o, rt, h, t, o);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int e;
    logic [10:0] exp_v;
    do_req(2'd1, 4'd10, 4'd2, 1'b0, e);
    exp_v = sb.pop_front();
    n_checks++;
    if (e !== 1) begin n_fail++; $display("FAIL illegal_latency: got %0d edges, want 1", e); end
    n_checks++;
    if (ERR !== 1'b1 || BIN !== 10'd0 || {ERR, BIN} !== exp_v) begin
      n_fail++; $display("FAIL illegal_result: got ERR=%b BIN=%h, want ERR=1 BIN=0", ERR, BIN);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL illegal_busy: got %b, want 1", busy); end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL illegal_single_done: got busy=%b done=%b, want 0 0", busy, done); end
    do_req(2'd0, 4'd0, 4'd7, 1'b0, e);
    exp_v = sb.pop_front();
    n_checks++;
    if (e !== 10 || ERR !== 1'b0 || BIN !== 10'd7 || {ERR, BIN} !== exp_v) begin
      n_fail++; $display("FAIL after_illegal: got ERR=%b BIN=%0d edges=%0d, want ERR=0 BIN=7 edges=10", ERR, BIN, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int t1 = -1;
    int t2 = -1;
    logic [9:0] b1 = 10'd0;
    logic [9:0] b2 = 10'd0;
    logic [10:0] exp1;
    logic [10:0] exp2;
    HUNDREDS = 2'd2; TENS = 4'd5; ONES = 4'd5; start = 1'b1;
    sb.push_back({1'b0, 10'd255});
    sb.push_back({1'b0, 10'd1});
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) begin t1 = c; b1 = BIN; end
        else if (dones == 2) begin t2 = c; b2 = BIN; end
      end
      HUNDREDS = 2'd0; TENS = 4'd0; ONES = 4'd1;
      if (c == 13) start = 1'b0;
    end
    exp1 = sb.pop_front();
    exp2 = sb.pop_front();
    n_checks++;
    if (dones !== 2) begin n_fail++; $display("FAIL busy_done_count: got %0d pulses, want 2", dones); end
    n_checks++;
    if (t1 !== 11 || b1 !== exp1[9:0]) begin
      n_fail++; $display("FAIL busy_first: got BIN=%0d at negedge %0d, want BIN=255 at 11", b1, t1);
    end
    n_checks++;
    if (t2 !== 23 || b2 !== exp2[9:0]) begin
      n_fail++; $display("FAIL busy_second: got BIN=%0d at negedge %0d, want BIN=1 at 23", b2, t2);
    end
  endtask

  task automatic test_midreset();
    int e;
    int dones = 0;
    logic [10:0] exp_v;
    HUNDREDS = 2'd1; TENS = 4'd2; ONES = 4'd3; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b, want 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({BIN, ERR, busy, done} !== 13'd0) begin
      n_fail++; $display("FAIL midreset_async: got BIN=%h ERR=%b busy=%b done=%b, want all 0", BIN, ERR, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 0 || BIN !== 10'd0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d pulses BIN=%0d, want 0 pulses BIN=0", dones, BIN);
    end
    do_req(2'd1, 4'd2, 4'd3, 1'b0, e);
    exp_v = sb.pop_front();
    n_checks++;
    if (e !== 10 || BIN !== 10'd123 || {ERR, BIN} !== exp_v) begin
      n_fail++; $display("FAIL midreset_fresh: got BIN=%0d edges=%0d, want BIN=123 edges=10", BIN, e);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    int e;
    logic [10:0] exp_v;
    do_req(2'd2, 4'd4, 4'd6, 1'b1, e);
    exp_v = sb.pop_front();
    n_checks++;
    if (e !== 10 || BIN !== 10'd246 || ERR !== 1'b0 || {ERR, BIN} !== exp_v) begin
      n_fail++; $display("FAIL input_hold: got BIN=%0d ERR=%b edges=%0d, want BIN=246 ERR=0 edges=10", BIN, ERR, e);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_max();
    test_sweep();
    test_illegal();
    test_back_to_back();
    test_midreset();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
